// File: rtl/match_collector_if.sv
// match_collector_if
// Bundles the window-input handshake and the result-output handshake of
// the match collector.
//   result, en, base_idx, in_valid : window from the router (to the collector)
//   in_ready                       : collector can take a window
//   out_idx, out_valid             : head of the result FIFO (from the collector)
//   out_ready                      : sink accepts out_idx
//   match_count, busy              : status from the collector
// Modports: master = router/sink side, slave = collector side.
interface match_collector_if #(
  parameter int num  = 4,
  parameter int IDXW = 16
);
  logic [num-1:0]  result;
  logic [num-1:0]  en;
  logic [IDXW-1:0] base_idx;
  logic            in_valid;
  logic            in_ready;
  logic [IDXW-1:0] out_idx;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] match_count;
  logic            busy;

  modport master (
    output result, en, base_idx, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, match_count, busy
  );

  modport slave (
    input  result, en, base_idx, in_valid, out_ready,
    output in_ready, out_idx, out_valid, match_count, busy
  );
endinterface

// File: rtl/match_collector.sv
// match_collector
// Masks the per-PE match bits of one compare window with the enables issued
// for it, then serializes every hit (lowest PE first) into a text-position
// index base+i and pushes it into a first-word-fall-through FIFO drained by
// a valid/ready sink. A full FIFO stalls the scan; a scan in progress holds
// in_ready low, so nothing is ever dropped.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : match_collector_if.slave (window input, result output, status)
module match_collector #(
  parameter int num   = 4,
  parameter int IDXW  = 16,
  parameter int DEPTH = 8
) (
  input logic            clk,
  input logic            reset,
  match_collector_if.slave bus
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam int IW   = (num > 1) ? $clog2(num) : 1;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [num-1:0]  hits_q, hits_d;
  logic [IDXW-1:0] base_q, base_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [IDXW-1:0] matchCount_q, matchCount_d;
  logic [IDXW-1:0] mem_q [DEPTH];

  logic [IW-1:0]   lowIdx;
  logic [IDXW-1:0] pushData;
  logic            full, empty, accept, push, pop;

  // Priority pick of the lowest pending hit; scanning downward lets the
  // lowest set bit win the last assignment.
  always_comb begin
    lowIdx = '0;
    for (int i = num - 1; i >= 0; i--) begin
      if (hits_q[i]) lowIdx = IW'(i);
    end
  end

  // Handshake qualifiers. The push decision looks only at the full flag
  // held from the previous edge, so a pop on a full FIFO frees the slot
  // for the following cycle rather than this one.
  always_comb begin
    full     = (count_q == CNTW'(DEPTH));
    empty    = (count_q == '0);
    accept   = bus.in_valid && (state_q == IDLE);
    push     = (state_q == SCAN) && !full;
    pop      = !empty && bus.out_ready;
    pushData = base_q + IDXW'(lowIdx);
  end

  // Next-state logic for the scan FSM, FIFO pointers and match counter.
  // hits & (hits-1) clears exactly the lowest set bit, which is the one
  // being pushed this cycle.
  always_comb begin
    state_d      = state_q;
    hits_d       = hits_q;
    base_d       = base_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    matchCount_d = matchCount_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hits_d = bus.result & bus.en;
          base_d = bus.base_idx;
          if ((bus.result & bus.en) != '0) state_d = SCAN;
        end
      end
      SCAN: begin
        if (push) begin
          hits_d = hits_q & (hits_q - num'(1));
          if ((hits_q & (hits_q - num'(1))) == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
      if (matchCount_q != '1) matchCount_d = matchCount_q + IDXW'(1);
    end
    if (pop) rdPtr_d = rdPtr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and control registers; reset discards any pending hits and
  // every queued entry on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hits_q       <= '0;
      base_q       <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      matchCount_q <= '0;
    end else begin
      state_q      <= state_d;
      hits_q       <= hits_d;
      base_q       <= base_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      matchCount_q <= matchCount_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while the
  // occupancy count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= pushData;
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = !empty;
  assign bus.out_idx     = empty ? '0 : mem_q[rdPtr_q];
  assign bus.match_count = matchCount_q;
  assign bus.busy        = (state_q == SCAN) || !empty;
endmodule

// File: tb/tb_match_collector.sv
// tb_match_collector
// Directed testbench for match_collector: single window, enable masking,
// zero-hit windows, FIFO backpressure, index wrap and reset mid-scan.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_match_collector;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  match_collector_if #(.num(4), .IDXW(16)) bus ();

  match_collector #(.num(4), .IDXW(16), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] res, input logic [3:0] e,
                               input logic [15:0] base, input logic valid);
    bus.result   = res;
    bus.en       = e;
    bus.base_idx = base;
    bus.in_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Offer a window, waiting (bounded) for in_ready, then take the accept edge.
  task automatic offerWindow(input logic [3:0] res, input logic [15:0] base);
    int waitCycles;
    applyStimulus(res, 4'b1111, base, 1'b1);
    waitCycles = 0;
    while (!bus.in_ready && waitCycles < 50) begin
      step();
      waitCycles++;
    end
    checkOutput("offer_timeout", 32'(waitCycles < 50), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    bus.out_ready = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 16'd0, 1'b0);
    doReset();

    // Reset state
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("rst_match_count", 32'(bus.match_count), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single window 1011 at base 100
    bus.out_ready = 1'b1;
    applyStimulus(4'b1011, 4'b1111, 16'd100, 1'b1);
    step();
    bus.in_valid = 1'b0;
    checkOutput("w1_in_ready_c1", 32'(bus.in_ready), 32'd0);
    checkOutput("w1_out_valid_c1", 32'(bus.out_valid), 32'd0);
    step();
    checkOutput("w1_out_valid_c2", 32'(bus.out_valid), 32'd1);
    checkOutput("w1_idx0", 32'(bus.out_idx), 32'd100);
    checkOutput("w1_in_ready_c2", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("w1_idx1", 32'(bus.out_idx), 32'd101);
    checkOutput("w1_in_ready_c3", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("w1_idx2", 32'(bus.out_idx), 32'd103);
    checkOutput("w1_in_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    checkOutput("w1_drained", 32'(bus.out_valid), 32'd0);
    checkOutput("w1_match_count", 32'(bus.match_count), 32'd3);
    checkOutput("w1_busy", 32'(bus.busy), 32'd0);

    // Enable mask, then a zero-hit window accepted as soon as in_ready rises
    applyStimulus(4'b1111, 4'b0101, 16'd8, 1'b1);
    step();
    applyStimulus(4'b0000, 4'b1111, 16'd77, 1'b1);
    checkOutput("m_in_ready_c1", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("m_idx0", 32'(bus.out_idx), 32'd8);
    checkOutput("m_in_ready_c2", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("m_idx1", 32'(bus.out_idx), 32'd10);
    checkOutput("m_in_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    checkOutput("m_zero_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("m_zero_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("m_match_count", 32'(bus.match_count), 32'd5);
    // Back-to-back zero-hit windows every cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 4'b1111, 16'(200 + i), 1'b1);
      step();
      checkOutput("z_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("z_out_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    step();
    checkOutput("z_match_count", 32'(bus.match_count), 32'd5);

    // Backpressure: three full windows into an 8-deep FIFO
    doReset();
    bus.out_ready = 1'b0;
    offerWindow(4'b1111, 16'd0);
    offerWindow(4'b1111, 16'd4);
    offerWindow(4'b1111, 16'd8);
    step();
    step();
    step();
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_busy", 32'(bus.busy), 32'd1);
    checkOutput("bp_count_full", 32'(bus.match_count), 32'd8);
    checkOutput("bp_head_hold", 32'(bus.out_idx), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_idx", 32'(bus.out_idx), 32'(i));
      step();
    end
    checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_match_count", 32'(bus.match_count), 32'd12);

    // Index wrap past 0xFFFF
    applyStimulus(4'b1110, 4'b1111, 16'hFFFE, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    checkOutput("wrap_idx0", 32'(bus.out_idx), 32'h0000FFFF);
    step();
    checkOutput("wrap_idx1", 32'(bus.out_idx), 32'h00000000);
    checkOutput("wrap_valid1", 32'(bus.out_valid), 32'd1);
    step();
    checkOutput("wrap_idx2", 32'(bus.out_idx), 32'h00000001);
    step();
    checkOutput("wrap_drained", 32'(bus.out_valid), 32'd0);
    checkOutput("wrap_match_count", 32'(bus.match_count), 32'd15);

    // Reset asserted on the edge of the second push of a 4-hit window
    applyStimulus(4'b1111, 4'b1111, 16'd20, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    checkOutput("rs_first_push", 32'(bus.out_idx), 32'd20);
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("rs_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rs_match_count", 32'(bus.match_count), 32'd0);
    checkOutput("rs_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rs_busy", 32'(bus.busy), 32'd0);
    applyStimulus(4'b0001, 4'b1111, 16'd50, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    checkOutput("rs_new_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("rs_new_idx", 32'(bus.out_idx), 32'd50);
    step();
    checkOutput("rs_new_drained", 32'(bus.out_valid), 32'd0);
    checkOutput("rs_new_count", 32'(bus.match_count), 32'd1);
    checkOutput("rs_new_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
